// File: rtl/conv_stream_master.sv
// conv_stream_master: holds one X and one F vector loaded by the host, streams both
// into the convolution block on start, and captures the returned y results for host readback.
module conv_stream_master #(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned OUT_WIDTH = 26,
  parameter int unsigned SIZE_X    = 112,
  parameter int unsigned SIZE_F    = 49,
  localparam int unsigned SIZE_Y    = SIZE_X - SIZE_F + 1,
  localparam int unsigned LOGSIZE_X = $clog2(SIZE_X),
  localparam int unsigned LOGSIZE_F = $clog2(SIZE_F),
  localparam int unsigned LOGSIZE_Y = $clog2(SIZE_Y)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        h_wr_en,
  input  logic                        h_sel,
  input  logic [LOGSIZE_X-1:0]        h_addr,
  input  logic signed [WIDTH-1:0]     h_wdata,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic signed [WIDTH-1:0]     x_data,
  output logic                        x_valid,
  input  logic                        x_ready,
  output logic signed [WIDTH-1:0]     f_data,
  output logic                        f_valid,
  input  logic                        f_ready,
  input  logic signed [OUT_WIDTH-1:0] y_data,
  input  logic                        y_valid,
  output logic                        y_ready,
  input  logic [LOGSIZE_Y-1:0]        r_addr,
  output logic signed [OUT_WIDTH-1:0] r_data
);

  // Counters must be able to hold the full length, one more than the largest address.
  localparam int unsigned XCW = $clog2(SIZE_X + 1);
  localparam int unsigned FCW = $clog2(SIZE_F + 1);
  localparam int unsigned YCW = $clog2(SIZE_Y + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic signed [WIDTH-1:0]     mem_x [SIZE_X];
  logic signed [WIDTH-1:0]     mem_f [SIZE_F];
  logic signed [OUT_WIDTH-1:0] mem_y [SIZE_Y];

  // x_idx/f_idx count completed transfers; x_rd/f_rd count memory fetches issued.
  logic [XCW-1:0]          x_idx, x_rd;
  logic [FCW-1:0]          f_idx, f_rd;
  logic [YCW-1:0]          y_cnt;
  logic signed [WIDTH-1:0] x_pf, f_pf;
  logic                    x_pf_vld, f_pf_vld;

  logic           launch_c, all_done_c, host_ok_c;
  logic           x_fire_c, x_take_c, x_fetch_c;
  logic           f_fire_c, f_take_c, f_fetch_c;
  logic           y_fire_c;
  logic [YCW-1:0] y_cnt_nxt_c;

  // Handshake decode: the output register reloads when empty or when its sample leaves;
  // the prefetch register refills whenever it is empty or being drained into the output.
  assign x_fire_c    = x_valid && x_ready;
  assign x_take_c    = !x_valid || x_fire_c;
  assign x_fetch_c   = (32'(x_rd) < SIZE_X) && (!x_pf_vld || x_take_c);
  assign f_fire_c    = f_valid && f_ready;
  assign f_take_c    = !f_valid || f_fire_c;
  assign f_fetch_c   = (32'(f_rd) < SIZE_F) && (!f_pf_vld || f_take_c);
  assign y_fire_c    = y_valid && y_ready;
  assign y_cnt_nxt_c = y_cnt + YCW'(y_fire_c);
  assign host_ok_c   = h_wr_en && (state != S_RUN);

  // Next-state logic; a run finishes only when both streams and all results are complete.
  always_comb begin
    state_nxt  = state;
    launch_c   = 1'b0;
    all_done_c = (x_idx == XCW'(SIZE_X)) && (f_idx == FCW'(SIZE_F)) && (y_cnt == YCW'(SIZE_Y));
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_RUN;
          launch_c  = 1'b1;
        end
      end
      S_RUN: begin
        if (all_done_c) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Registered status; y_ready drops on the same edge that captures the last result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      y_ready <= 1'b0;
    end else begin
      busy    <= (state_nxt == S_RUN);
      done    <= (state_nxt == S_DONE);
      y_ready <= (state_nxt == S_RUN) && (launch_c || (32'(y_cnt_nxt_c) < SIZE_Y));
    end
  end

  // Result counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        y_cnt <= '0;
    else if (launch_c) y_cnt <= '0;
    else if (y_fire_c) y_cnt <= y_cnt_nxt_c;
  end

  // X stream: registered memory read into a one-entry prefetch, then into the output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_idx    <= '0;
      x_rd     <= '0;
      x_pf     <= '0;
      x_pf_vld <= 1'b0;
      x_data   <= '0;
      x_valid  <= 1'b0;
    end else if (launch_c) begin
      x_idx    <= '0;
      x_rd     <= '0;
      x_pf_vld <= 1'b0;
      x_valid  <= 1'b0;
    end else if (state == S_RUN) begin
      if (x_fire_c) x_idx <= x_idx + XCW'(1);
      if (x_take_c) begin
        x_valid <= x_pf_vld;
        if (x_pf_vld) x_data <= x_pf;
      end
      if (x_fetch_c) begin
        x_pf     <= mem_x[x_rd[LOGSIZE_X-1:0]];
        x_pf_vld <= 1'b1;
        x_rd     <= x_rd + XCW'(1);
      end else if (x_take_c) begin
        x_pf_vld <= 1'b0;
      end
    end
  end

  // F stream: same structure as X, running independently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_idx    <= '0;
      f_rd     <= '0;
      f_pf     <= '0;
      f_pf_vld <= 1'b0;
      f_data   <= '0;
      f_valid  <= 1'b0;
    end else if (launch_c) begin
      f_idx    <= '0;
      f_rd     <= '0;
      f_pf_vld <= 1'b0;
      f_valid  <= 1'b0;
    end else if (state == S_RUN) begin
      if (f_fire_c) f_idx <= f_idx + FCW'(1);
      if (f_take_c) begin
        f_valid <= f_pf_vld;
        if (f_pf_vld) f_data <= f_pf;
      end
      if (f_fetch_c) begin
        f_pf     <= mem_f[f_rd[LOGSIZE_F-1:0]];
        f_pf_vld <= 1'b1;
        f_rd     <= f_rd + FCW'(1);
      end else if (f_take_c) begin
        f_pf_vld <= 1'b0;
      end
    end
  end

  // Memory writes: host loads outside RUN with range check, result capture during RUN.
  always_ff @(posedge clk) begin
    if (host_ok_c && !h_sel && (32'(h_addr) < SIZE_X))
      mem_x[h_addr] <= h_wdata;
    if (host_ok_c && h_sel && (32'(h_addr[LOGSIZE_F-1:0]) < SIZE_F))
      mem_f[h_addr[LOGSIZE_F-1:0]] <= h_wdata;
    if (y_fire_c)
      mem_y[y_cnt[LOGSIZE_Y-1:0]] <= y_data;
  end

  // Registered host result read, zero for addresses past the result length.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      r_data <= '0;
    else if (32'(r_addr) < SIZE_Y)   r_data <= mem_y[r_addr];
    else                             r_data <= '0;
  end

endmodule

// File: tb/tb_conv_stream_master.sv
// tb_conv_stream_master: drives host loads and runs, acts as the convolution block
// (sink computes y from its own copy of X and F), and checks streams and readback.
module tb_conv_stream_master;

  localparam int WIDTH     = 10;
  localparam int OUT_WIDTH = 26;
  localparam int SIZE_X    = 112;
  localparam int SIZE_F    = 49;
  localparam int SIZE_Y    = SIZE_X - SIZE_F + 1;
  localparam int LOGSIZE_X = 7;
  localparam int LOGSIZE_Y = 6;

  logic                        clk = 1'b0;
  logic                        reset = 1'b0;
  logic                        h_wr_en = 1'b0;
  logic                        h_sel = 1'b0;
  logic [LOGSIZE_X-1:0]        h_addr = '0;
  logic signed [WIDTH-1:0]     h_wdata = '0;
  logic                        start = 1'b0;
  logic                        busy, done;
  logic signed [WIDTH-1:0]     x_data, f_data;
  logic                        x_valid, f_valid;
  logic                        x_ready = 1'b0;
  logic                        f_ready = 1'b0;
  logic signed [OUT_WIDTH-1:0] y_data = '0;
  logic                        y_valid = 1'b0;
  logic                        y_ready;
  logic [LOGSIZE_Y-1:0]        r_addr = '0;
  logic signed [OUT_WIDTH-1:0] r_data;

  conv_stream_master dut (
    .clk(clk), .reset(reset),
    .h_wr_en(h_wr_en), .h_sel(h_sel), .h_addr(h_addr), .h_wdata(h_wdata),
    .start(start), .busy(busy), .done(done),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .f_data(f_data), .f_valid(f_valid), .f_ready(f_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
    .r_addr(r_addr), .r_data(r_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: vector contents as the host believes them, expected results.
  int mx [SIZE_X];
  int mf [SIZE_F];
  int y_src [SIZE_Y];
  int rb [SIZE_Y];

  // Observations of the last run.
  int xq[$], fq[$], xt[$], ft[$];
  int acc, stall_viol, yr_viol;
  bit done_seen, timed_out, first_ok;

  // True convolution of the host vectors: y[k] = sum_j X[k+j] * F[SIZE_F-1-j].
  function automatic int conv_ref(input int k);
    int s = 0;
    for (int j = 0; j < SIZE_F; j++) s += mx[k+j] * mf[SIZE_F-1-j];
    return s;
  endfunction

  function automatic logic rdy(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 2) == 1;
      2:       return (c % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  function automatic int x_stream_errs();
    int n = 0;
    if (xq.size() != SIZE_X) return 1000 + xq.size();
    for (int i = 0; i < SIZE_X; i++) if (xq[i] != mx[i]) n++;
    return n;
  endfunction

  function automatic int f_stream_errs();
    int n = 0;
    if (fq.size() != SIZE_F) return 1000 + fq.size();
    for (int i = 0; i < SIZE_F; i++) if (fq[i] != mf[i]) n++;
    return n;
  endfunction

  function automatic int result_errs();
    int n = 0;
    for (int i = 0; i < SIZE_Y; i++) if (rb[i] != y_src[i]) n++;
    return n;
  endfunction

  task automatic host_write(input bit sel, input int addr, input int data);
    h_wr_en = 1'b1; h_sel = sel; h_addr = LOGSIZE_X'(addr); h_wdata = WIDTH'(data);
    @(posedge clk); #1;
    h_wr_en = 1'b0;
  endtask

  // Push the whole reference model into the DUT memories.
  task automatic load_model();
    @(posedge clk); #1;
    for (int i = 0; i < SIZE_X; i++) host_write(1'b0, i, mx[i]);
    for (int j = 0; j < SIZE_F; j++) host_write(1'b1, j, mf[j]);
  endtask

  task automatic read_results();
    @(posedge clk); #1;
    for (int i = 0; i < SIZE_Y; i++) begin
      r_addr = LOGSIZE_Y'(i);
      @(posedge clk); #1;
      rb[i] = int'(r_data);
    end
  endtask

  // One run: start (optionally with a same-cycle write), then act as the convolution block.
  task automatic run_once(input int xm, input int fm, input int ym, input int ylim,
                          input int abort_x, input int illegal_at,
                          input bit wr_start, input int wr_addr, input int wr_data,
                          input int budget);
    int c = 0;
    int offers = 0;
    bit pend_x = 0, pend_f = 0;
    logic signed [WIDTH-1:0] hold_x = '0, hold_f = '0;
    xq.delete(); fq.delete(); xt.delete(); ft.delete();
    acc = 0; stall_viol = 0; yr_viol = 0;
    done_seen = 0; timed_out = 0; first_ok = 0;
    for (int k = 0; k < SIZE_Y; k++) y_src[k] = conv_ref(k);
    @(posedge clk); #1;
    start = 1'b1;
    if (wr_start) begin
      h_wr_en = 1'b1; h_sel = 1'b0; h_addr = LOGSIZE_X'(wr_addr); h_wdata = WIDTH'(wr_data);
    end
    @(posedge clk);
    forever begin
      @(posedge clk); c++;
      #1;
      start = 1'b0; h_wr_en = 1'b0;
      if (c == illegal_at) begin
        start = 1'b1; h_wr_en = 1'b1; h_sel = 1'b0; h_addr = LOGSIZE_X'(5); h_wdata = WIDTH'(7);
      end
      x_ready = rdy(xm, c);
      f_ready = rdy(fm, c);
      y_valid = (offers < ylim) && (ym == 0 || $urandom_range(0, 1) == 1);
      if (y_valid) offers++;
      y_data = (acc < SIZE_Y) ? OUT_WIDTH'(y_src[acc]) : OUT_WIDTH'($urandom);
      @(negedge clk);
      if (c == 1) first_ok = busy && y_ready && !x_valid && !f_valid && !done;
      if (pend_x && (!x_valid || x_data !== hold_x)) stall_viol++;
      if (pend_f && (!f_valid || f_data !== hold_f)) stall_viol++;
      pend_x = x_valid && !x_ready; hold_x = x_data;
      pend_f = f_valid && !f_ready; hold_f = f_data;
      if (x_valid && x_ready) begin xq.push_back(int'(x_data)); xt.push_back(c); end
      if (f_valid && f_ready) begin fq.push_back(int'(f_data)); ft.push_back(c); end
      if (acc >= SIZE_Y && y_ready) yr_viol++;
      if (y_valid && y_ready) acc++;
      if (done) begin done_seen = 1; break; end
      if (abort_x > 0 && xq.size() >= abort_x) break;
      if (c >= budget) begin timed_out = 1; break; end
    end
    x_ready = 1'b0; f_ready = 1'b0; y_valid = 1'b0; start = 1'b0; h_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, x_valid, f_valid, y_ready} !== 5'b0 || x_data !== '0 || f_data !== '0 || r_data !== '0) begin
      errors++;
      $display("FAIL reset_values: busy=%b done=%b xv=%b fv=%b yr=%b xd=%0d fd=%0d rd=%0d, want all 0",
               busy, done, x_valid, f_valid, y_ready, x_data, f_data, r_data);
    end
    reset = 1'b1;
  endtask

  task automatic test_unity();
    int bad_t = 0;
    for (int i = 0; i < SIZE_X; i++) mx[i] = 1;
    for (int j = 0; j < SIZE_F; j++) mf[j] = 1;
    load_model();
    run_once(0, 0, 0, SIZE_Y, 0, 0, 1'b0, 0, 0, 400);
    checks++;
    if (!first_ok) begin errors++; $display("FAIL unity_first_cycle: busy/y_ready not high or valid early, want busy=1 y_ready=1 x/f_valid=0"); end
    checks++;
    if (!done_seen) begin errors++; $display("FAIL unity_done: done=%b timed_out=%b, want done=1", done, timed_out); end
    checks++;
    if (x_stream_errs() != 0) begin errors++; $display("FAIL unity_x_stream: %0d bad (size %0d), want 0 bad size %0d", x_stream_errs(), xq.size(), SIZE_X); end
    for (int k = 0; k < xt.size(); k++) if (xt[k] != k + 2) bad_t++;
    for (int k = 0; k < ft.size(); k++) if (ft[k] != k + 2) bad_t++;
    checks++;
    if (bad_t != 0 || xt.size() != SIZE_X) begin errors++; $display("FAIL unity_timing: %0d samples off cycle start+2+k, want 0", bad_t); end
    checks++;
    if (f_stream_errs() != 0) begin errors++; $display("FAIL unity_f_stream: %0d bad (size %0d), want 0", f_stream_errs(), fq.size()); end
    checks++;
    if (busy !== 1'b0 || y_ready !== 1'b0 || x_valid !== 1'b0 || f_valid !== 1'b0) begin
      errors++; $display("FAIL unity_end_flags: busy=%b yr=%b xv=%b fv=%b, want all 0", busy, y_ready, x_valid, f_valid);
    end
    read_results();
    for (int i = 0; i < SIZE_Y; i++) begin
      checks++;
      if (rb[i] != 49) begin errors++; $display("FAIL unity_result[%0d]: got %0d want 49", i, rb[i]); end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < SIZE_X; i++) mx[i] = i;
    for (int j = 0; j < SIZE_F; j++) mf[j] = j;
    load_model();
    run_once(1, 2, 3, 100000, 0, 0, 1'b0, 0, 0, 1000);
    checks++;
    if (!done_seen) begin errors++; $display("FAIL bp_done: done=%b, want 1", done); end
    checks++;
    if (x_stream_errs() != 0) begin errors++; $display("FAIL bp_x_stream: %0d bad (size %0d), want 0", x_stream_errs(), xq.size()); end
    checks++;
    if (f_stream_errs() != 0) begin errors++; $display("FAIL bp_f_stream: %0d bad (size %0d), want 0", f_stream_errs(), fq.size()); end
    checks++;
    if (stall_viol != 0) begin errors++; $display("FAIL bp_stall_stable: %0d stall changes, want 0", stall_viol); end
    read_results();
    checks++;
    if (result_errs() != 0) begin errors++; $display("FAIL bp_results: %0d bad, want 0 (r[0]=%0d want %0d)", result_errs(), rb[0], y_src[0]); end
  endtask

  task automatic test_extreme();
    for (int i = 0; i < SIZE_X; i++) mx[i] = -512;
    for (int j = 0; j < SIZE_F; j++) mf[j] = 511;
    load_model();
    run_once(0, 0, 0, SIZE_Y, 0, 0, 1'b0, 0, 0, 400);
    checks++;
    if (!done_seen || x_stream_errs() != 0 || f_stream_errs() != 0) begin
      errors++; $display("FAIL extreme_run: done=%b xerr=%0d ferr=%0d, want 1/0/0", done_seen, x_stream_errs(), f_stream_errs());
    end
    read_results();
    for (int i = 0; i < SIZE_Y; i++) begin
      checks++;
      if (rb[i] != -12819968) begin errors++; $display("FAIL extreme_result[%0d]: got %0d want -12819968", i, rb[i]); end
    end
  endtask

  task automatic test_excess_y();
    for (int i = 0; i < SIZE_X; i++) mx[i] = int'($urandom_range(0, 1023)) - 512;
    for (int j = 0; j < SIZE_F; j++) mf[j] = int'($urandom_range(0, 1023)) - 512;
    load_model();
    run_once(0, 0, 0, 70, 0, 0, 1'b0, 0, 0, 400);
    checks++;
    if (acc != SIZE_Y) begin errors++; $display("FAIL excess_accept_count: got %0d want %0d", acc, SIZE_Y); end
    checks++;
    if (yr_viol != 0) begin errors++; $display("FAIL excess_y_ready_low: y_ready high %0d cycles after 64th, want 0", yr_viol); end
    checks++;
    if (!done_seen) begin errors++; $display("FAIL excess_done: done=%b want 1", done); end
    read_results();
    checks++;
    if (result_errs() != 0) begin errors++; $display("FAIL excess_results: %0d bad, want 0", result_errs()); end
  endtask

  task automatic test_illegal_in_run();
    int old5;
    for (int i = 0; i < SIZE_X; i++) mx[i] = int'($urandom_range(0, 1023)) - 512;
    mx[5] = 100;
    load_model();
    old5 = mx[5];
    run_once(0, 0, 0, SIZE_Y, 0, 10, 1'b0, 0, 0, 400);
    checks++;
    if (!done_seen || x_stream_errs() != 0 || f_stream_errs() != 0 || acc != SIZE_Y) begin
      errors++; $display("FAIL illegal_run: done=%b xerr=%0d ferr=%0d acc=%0d, want 1/0/0/%0d",
                         done_seen, x_stream_errs(), f_stream_errs(), acc, SIZE_Y);
    end
    run_once(0, 0, 0, SIZE_Y, 0, 0, 1'b0, 0, 0, 400);
    checks++;
    if (xq.size() != SIZE_X || xq[5] != old5) begin
      errors++; $display("FAIL illegal_write_dropped: X[5]=%0d (size %0d) want %0d", (xq.size() > 5) ? xq[5] : -9999, xq.size(), old5);
    end
  endtask

  task automatic test_start_with_write();
    mx[3] = -77;
    run_once(0, 0, 0, SIZE_Y, 0, 0, 1'b1, 3, -77, 400);
    checks++;
    if (xq.size() != SIZE_X || xq[3] != -77) begin
      errors++; $display("FAIL start_write_x3: X[3]=%0d want -77", (xq.size() > 3) ? xq[3] : -9999);
    end
    checks++;
    if (!done_seen || x_stream_errs() != 0) begin errors++; $display("FAIL start_write_run: done=%b xerr=%0d, want 1/0", done_seen, x_stream_errs()); end
  endtask

  task automatic test_reset_mid_run();
    run_once(0, 0, 0, 100000, 40, 0, 1'b0, 0, 0, 400);
    checks++;
    if (xq.size() != 40 || done_seen) begin errors++; $display("FAIL midrst_reach: %0d transfers done=%b, want 40 and 0", xq.size(), done_seen); end
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, x_valid, f_valid, y_ready} !== 5'b0 || x_data !== '0 || f_data !== '0 || r_data !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: busy=%b done=%b xv=%b fv=%b yr=%b xd=%0d fd=%0d rd=%0d, want all 0",
               busy, done, x_valid, f_valid, y_ready, x_data, f_data, r_data);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    run_once(0, 0, 0, SIZE_Y, 0, 0, 1'b0, 0, 0, 400);
    checks++;
    if (!done_seen || x_stream_errs() != 0 || f_stream_errs() != 0) begin
      errors++; $display("FAIL midrst_rerun: done=%b xerr=%0d ferr=%0d, want 1/0/0", done_seen, x_stream_errs(), f_stream_errs());
    end
    read_results();
    checks++;
    if (result_errs() != 0) begin errors++; $display("FAIL midrst_results: %0d bad, want 0", result_errs()); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 2; it++) begin
      for (int i = 0; i < SIZE_X; i++) mx[i] = int'($urandom_range(0, 1023)) - 512;
      for (int j = 0; j < SIZE_F; j++) mf[j] = int'($urandom_range(0, 1023)) - 512;
      load_model();
      run_once(3, 3, 3, 100000, 0, 0, 1'b0, 0, 0, 2000);
      checks++;
      if (!done_seen || x_stream_errs() != 0 || f_stream_errs() != 0 || stall_viol != 0) begin
        errors++; $display("FAIL random_run%0d: done=%b xerr=%0d ferr=%0d stall=%0d, want 1/0/0/0",
                           it, done_seen, x_stream_errs(), f_stream_errs(), stall_viol);
      end
      read_results();
      checks++;
      if (result_errs() != 0) begin errors++; $display("FAIL random_results%0d: %0d bad, want 0", it, result_errs()); end
    end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_backpressure();
    test_extreme();
    test_excess_y();
    test_illegal_in_run();
    test_start_with_write();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
